// File: rtl/semi_auto_command_issuer_pkg.sv
// Shared types and defaults for the semi-auto command issuer: FSM states,
// command codes and the helpers that map button presses onto commands.
package semi_auto_command_issuer_pkg;

  localparam int unsigned DEBOUNCE_TICKS_DEF    = 3;
  localparam int unsigned ACK_TIMEOUT_TICKS_DEF = 50;
  localparam int unsigned CNT_W_DEF             = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_ISSUE,
    ST_BUSY
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE     = 3'd0,
    CMD_STRAIGHT = 3'd1,
    CMD_RIGHT    = 3'd2,
    CMD_LEFT     = 3'd3,
    CMD_BACK     = 3'd4
  } cmd_t;

  // press bit order: [0] straight, [1] right, [2] left, [3] back.
  // Priority follows the driving controller's decode order.
  function automatic cmd_t encode_press(input logic [3:0] press);
    if (press[0]) return CMD_STRAIGHT;
    if (press[1]) return CMD_RIGHT;
    if (press[2]) return CMD_LEFT;
    if (press[3]) return CMD_BACK;
    return CMD_NONE;
  endfunction

  function automatic logic [3:0] cmd_onehot(input cmd_t cmd);
    case (cmd)
      CMD_STRAIGHT: return 4'b0001;
      CMD_RIGHT:    return 4'b0010;
      CMD_LEFT:     return 4'b0100;
      CMD_BACK:     return 4'b1000;
      default:      return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/semi_auto_command_issuer_btn_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter and a
// one-tick pulse on each accepted rising edge of the button level.
module btn_debouncer
  import semi_auto_command_issuer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic clk_100hz,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk_100hz) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
        level <= sync_b;
        press <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/semi_auto_command_issuer.sv
// Semi-auto command initiator: debounces four direction buttons and holds one
// one-hot command until the driving controller acknowledges by moving.
module semi_auto_command_issuer
  import semi_auto_command_issuer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS    = DEBOUNCE_TICKS_DEF,
  parameter int unsigned ACK_TIMEOUT_TICKS = ACK_TIMEOUT_TICKS_DEF,
  parameter int unsigned CNT_W             = CNT_W_DEF
) (
  input  logic       clk_100hz,
  input  logic       reset,
  input  logic       semi_auto_mode_on,
  input  logic       btn_straight,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_back,
  input  logic       move_forward_signal,
  input  logic       turn_left_signal,
  input  logic       turn_right_signal,
  input  logic       move_backward_signal,
  output logic       go_straight_command,
  output logic       turn_right_command,
  output logic       turn_left_command,
  output logic       turn_back_command,
  output logic       cmd_pending,
  output logic       cmd_timeout,
  output logic [2:0] last_cmd
);

  logic [3:0]       press;
  state_t           state, state_n;
  cmd_t             code, code_n;
  cmd_t             last_q, last_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       cmd, cmd_n;
  logic             timeout_n;
  logic             moving, idle_q, idle2;

  btn_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_db_straight (
    .clk_100hz(clk_100hz), .reset(reset), .btn(btn_straight), .press(press[0]));
  btn_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_db_right (
    .clk_100hz(clk_100hz), .reset(reset), .btn(btn_right), .press(press[1]));
  btn_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_db_left (
    .clk_100hz(clk_100hz), .reset(reset), .btn(btn_left), .press(press[2]));
  btn_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_db_back (
    .clk_100hz(clk_100hz), .reset(reset), .btn(btn_back), .press(press[3]));

  assign moving = move_forward_signal | turn_left_signal | turn_right_signal | move_backward_signal;
  // controller outputs are registered, so a single idle tick may be transient
  assign idle2  = !moving && idle_q;

  always_ff @(posedge clk_100hz) begin
    if (reset) begin
      state       <= ST_IDLE;
      code        <= CMD_NONE;
      last_q      <= CMD_NONE;
      cnt         <= '0;
      cmd         <= '0;
      cmd_timeout <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      state       <= state_n;
      code        <= code_n;
      last_q      <= last_n;
      cnt         <= cnt_n;
      cmd         <= cmd_n;
      cmd_timeout <= timeout_n;
      idle_q      <= !moving;
    end
  end

  always_comb begin
    state_n   = state;
    code_n    = code;
    last_n    = last_q;
    cnt_n     = cnt;
    timeout_n = cmd_timeout;
    if (!semi_auto_mode_on) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (idle2) state_n = ST_ARM;
        ST_ARM: begin
          if (|press) begin
            code_n  = encode_press(press);
            cnt_n   = '0;
            state_n = ST_ISSUE;
          end else if (moving) begin
            state_n = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (moving) begin
            state_n   = ST_BUSY;
            last_n    = code;
            timeout_n = 1'b0;
          end else if (cnt == CNT_W'(ACK_TIMEOUT_TICKS - 1)) begin
            state_n   = ST_IDLE;
            timeout_n = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_BUSY: if (idle2) state_n = ST_ARM;
        default: state_n = ST_IDLE;
      endcase
    end
    // commands are registered from the next state so they never glitch
    cmd_n = (state_n == ST_ISSUE) ? cmd_onehot(code_n) : '0;
  end

  assign go_straight_command = cmd[0];
  assign turn_right_command  = cmd[1];
  assign turn_left_command   = cmd[2];
  assign turn_back_command   = cmd[3];
  assign cmd_pending         = (state == ST_ISSUE);
  assign last_cmd            = last_q;

endmodule
